// File: rtl/vga_pkg.sv
// Default 800x600@60 timing constants shared by the VGA timing generator,
// plus a width check helper used at elaboration.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_H_FP     = 40;
  localparam int unsigned VGA_H_SYNC   = 128;
  localparam int unsigned VGA_H_BP     = 88;
  localparam int unsigned VGA_V_ACTIVE = 600;
  localparam int unsigned VGA_V_FP     = 1;
  localparam int unsigned VGA_V_SYNC   = 4;
  localparam int unsigned VGA_V_BP     = 23;
  localparam int unsigned VGA_CW       = 11;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  function automatic bit fits(input int unsigned total, input int unsigned cw);
    return 64'(total) <= (64'd1 << cw);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable in, timing/position outputs back; master is the generator.
interface vga_timing_gen_if import vga_pkg::*; #(parameter int unsigned CW = VGA_CW);
  logic          en;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          end_of_line;
  logic          end_of_frame;
  logic          frame_start;

  modport master (input en, output hcount, vcount, hsync, vsync, hblnk, vblnk,
                  end_of_line, end_of_frame, frame_start);
  modport slave  (output en, input hcount, vcount, hsync, vsync, hblnk, vblnk,
                  end_of_line, end_of_frame, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter with count enable. o_next is the value loaded at the
// coming edge so the parent can register decodes aligned with the count.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 1056,
  parameter int unsigned CW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ce,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_next,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_inc;

  // >= rather than == keeps the counter inside 0..TOTAL-1 whatever its state
  assign o_wrap  = i_ce && (r_cnt >= LAST);
  assign w_inc   = o_wrap ? '0 : r_cnt + 1'b1;
  assign o_next  = i_ce ? w_inc : r_cnt;
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= o_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/strobe generator. All outputs are registered from the next
// counter values so they line up with the hcount/vcount they describe.
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic              pclk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!fits(H_TOTAL, CW) || !fits(V_TOTAL, CW)) begin : g_cw_chk
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  // thresholds one bit wider so sync end == 2**CW still compares correctly
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] H_LST  = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] V_LST  = (CW+1)'(V_TOTAL - 1);

  logic          w_adv, w_hwrap, w_vwrap;
  logic [CW-1:0] w_hcount, w_vcount, w_hnext, w_vnext;
  logic [CW:0]   w_hn, w_vn;
  logic          r_pend;
  logic          r_hsync, r_vsync, r_hblnk, r_vblnk, r_eol, r_eof, r_fs;

  // after reset the first en cycle announces (0,0) with frame_start
  // before the counters start moving
  assign w_adv = bus.en && !r_pend;

  vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_hcnt (
    .clk(pclk), .rst(rst), .i_ce(w_adv),
    .o_count(w_hcount), .o_next(w_hnext), .o_wrap(w_hwrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_vcnt (
    .clk(pclk), .rst(rst), .i_ce(w_hwrap),
    .o_count(w_vcount), .o_next(w_vnext), .o_wrap(w_vwrap)
  );

  assign w_hn = {1'b0, w_hnext};
  assign w_vn = {1'b0, w_vnext};

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_pend  <= 1'b1;
      r_hblnk <= 1'b0;
      r_vblnk <= 1'b0;
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_fs    <= 1'b0;
    end else if (bus.en) begin
      r_pend  <= 1'b0;
      r_hblnk <= (w_hn >= H_ACT);
      r_vblnk <= (w_vn >= V_ACT);
      r_hsync <= (w_hn >= HS_BEG && w_hn < HS_END) ? HS_POL : ~HS_POL;
      r_vsync <= (w_vn >= VS_BEG && w_vn < VS_END) ? VS_POL : ~VS_POL;
      r_eol   <= (w_hn == H_LST);
      r_eof   <= (w_hn == H_LST) && (w_vn == V_LST);
      r_fs    <= w_vwrap || r_pend;
    end else begin
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_fs    <= 1'b0;
    end
  end

  assign bus.hcount       = w_hcount;
  assign bus.vcount       = w_vcount;
  assign bus.hsync        = r_hsync;
  assign bus.vsync        = r_vsync;
  assign bus.hblnk        = r_hblnk;
  assign bus.vblnk        = r_vblnk;
  assign bus.end_of_line  = r_eol;
  assign bus.end_of_frame = r_eof;
  assign bus.frame_start  = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generator instances (default, 640x480 active-low, tiny mixed
// polarity) driven by shared rst/en and checked against a position model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] h, v;
    logic hs, vs, hb, vb, eol, eof, fs;
  } out_t;

  typedef struct packed {
    out_t o;
    logic en, rst;
  } exp_t;

  typedef struct {
    int ht, ha, hsb, hse, vt, va, vsb, vse;
    bit hp, vp;
  } tm_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  vga_timing_gen_if #(.CW(11)) if_def ();
  vga_timing_gen_if #(.CW(10)) if_vga ();
  vga_timing_gen_if #(.CW(5))  if_sml ();

  vga_timing_gen #(.CW(11)) u_def (.pclk(pclk), .rst(rst), .bus(if_def));

  vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                   .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(10))
    u_vga (.pclk(pclk), .rst(rst), .bus(if_vga));

  vga_timing_gen #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .HS_POL(1'b1), .VS_POL(1'b0), .CW(5))
    u_sml (.pclk(pclk), .rst(rst), .bus(if_sml));

  tm_t    tm[3];
  longint ticks[3];
  bit     pend[3];
  exp_t   q0[$], q1[$], q2[$];
  string  nm[3] = '{"def", "vga", "sml"};

  int n_chk = 0, n_fail = 0;
  bit meas = 0;
  int cnt = 0, eolc = 0, frames = 0;

  function automatic tm_t mk_tm(int ha, int hfp, int hs, int hbp, int va, int vfp,
                                int vs, int vbp, bit hp, bit vp);
    tm_t t;
    t.ha = ha; t.hsb = ha + hfp; t.hse = ha + hfp + hs; t.ht = ha + hfp + hs + hbp;
    t.va = va; t.vsb = va + vfp; t.vse = va + vfp + vs; t.vt = va + vfp + vs + vbp;
    t.hp = hp; t.vp = vp;
    return t;
  endfunction

  // position = number of advances since reset, folded into the frame
  function automatic out_t derive(int i);
    out_t o;
    longint p;
    int h, v;
    p = ticks[i] % longint'(tm[i].ht * tm[i].vt);
    h = int'(p % tm[i].ht);
    v = int'(p / tm[i].ht);
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.hb  = (h >= tm[i].ha);
    o.vb  = (v >= tm[i].va);
    o.hs  = (h >= tm[i].hsb && h < tm[i].hse) ? tm[i].hp : !tm[i].hp;
    o.vs  = (v >= tm[i].vsb && v < tm[i].vse) ? tm[i].vp : !tm[i].vp;
    o.eol = (h == tm[i].ht - 1);
    o.eof = o.eol && (v == tm[i].vt - 1);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t mk(int h, int v, logic hs, logic vs, logic hb, logic vb,
                              logic eol, logic eof, logic fs);
    out_t o;
    o.h = 16'(h); o.v = 16'(v); o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb;
    o.eol = eol; o.eof = eof; o.fs = fs;
    return o;
  endfunction

  task automatic step(input bit r, input bit e);
    exp_t x;
    @(negedge pclk);
    rst = r;
    if_def.en = e; if_vga.en = e; if_sml.en = e;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        ticks[i] = 0; pend[i] = 1'b1;
        x.o = derive(i);
        x.o.eol = 0; x.o.eof = 0; x.o.fs = 0;
      end else if (e) begin
        if (pend[i]) pend[i] = 1'b0;
        else         ticks[i]++;
        x.o = derive(i);
      end else begin
        x.o = derive(i);
        x.o.eol = 0; x.o.eof = 0; x.o.fs = 0;
      end
      x.en = e; x.rst = r;
      case (i)
        0: q0.push_back(x);
        1: q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
  endtask

  task automatic check(input int i, input out_t w, input out_t a);
    n_chk++;
    if (a !== w) begin
      n_fail++;
      $display("FAIL %s outputs @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b eol=%b eof=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b eol=%b eof=%b fs=%b",
               nm[i], $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.eol, a.eof, a.fs,
               w.h, w.v, w.hs, w.vs, w.hb, w.vb, w.eol, w.eof, w.fs);
    end
  endtask

  task automatic tcheck(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // monitor: pops one expectation per DUT after every edge that has one
  initial begin : mon
    exp_t e;
    out_t a;
    forever begin
      @(posedge pclk); #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = mk(int'(if_def.hcount), int'(if_def.vcount), if_def.hsync, if_def.vsync,
               if_def.hblnk, if_def.vblnk, if_def.end_of_line, if_def.end_of_frame,
               if_def.frame_start);
        check(0, e.o, a);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = mk(int'(if_vga.hcount), int'(if_vga.vcount), if_vga.hsync, if_vga.vsync,
               if_vga.hblnk, if_vga.vblnk, if_vga.end_of_line, if_vga.end_of_frame,
               if_vga.frame_start);
        check(1, e.o, a);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        a = mk(int'(if_sml.hcount), int'(if_sml.vcount), if_sml.hsync, if_sml.vsync,
               if_sml.hblnk, if_sml.vblnk, if_sml.end_of_line, if_sml.end_of_frame,
               if_sml.frame_start);
        check(2, e.o, a);
        // frame length in en cycles, measured from the DUT's own strobes
        if (e.rst) meas = 0;
        else if (e.en) begin
          if (meas) begin
            cnt++;
            if (a.eol) eolc++;
          end
          if (a.fs) begin
            if (meas) begin
              tcheck("sml frame en cycles", cnt, tm[2].ht * tm[2].vt);
              tcheck("sml eol per frame", eolc, tm[2].vt);
              frames++;
            end
            meas = 1; cnt = 0; eolc = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int k;
    out_t p;
    tm[0] = mk_tm(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    tm[1] = mk_tm(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    tm[2] = mk_tm(10, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b0);
    if_def.en = 0; if_vga.en = 0; if_sml.en = 0;

    repeat (3) step(1, 0);
    repeat (1800) step(0, 1);
    repeat (4000) step(0, 1'($urandom_range(0, 1)));

    // reset while the default instance is inside its hsync pulse
    k = 0;
    while (derive(0).h != 900 && k < 1100) begin step(0, 1); k++; end
    tcheck("wait def h=900", int'(derive(0).h), 900);
    step(1, 1);
    repeat (2) step(0, 0);
    repeat (60) step(0, 1);

    // reset while the small instance has both syncs asserted
    k = 0;
    p = derive(2);
    while (!(p.h >= tm[2].hsb && p.h < tm[2].hse && p.v >= tm[2].vsb && p.v < tm[2].vse)
           && k < 400) begin
      step(0, 1); k++; p = derive(2);
    end
    tcheck("wait sml in sync", k < 400 ? 1 : 0, 1);
    step(1, 1);
    repeat (450) step(0, 1'($urandom_range(0, 3) != 0));

    repeat (3) @(posedge pclk);
    #2;
    tcheck("sml frames measured >= 3", frames >= 3 ? 1 : 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, H_SYNC, H_BP, defaults 40, 128, 88, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 Parameter V_FP, V_SYNC, V_BP, defaults 1, 4, 23, vertical front porch, sync and back porch in lines.
REQ-005 Parameter HS_POL, VS_POL, default 1, sync polarity: 1 = active-high pulse, 0 = active-low pulse.
REQ-006 Parameter CW, default 11, counter width; elaboration shall fail if H_TOTAL or V_TOTAL exceeds 2**CW.
REQ-007 pclk  input  1  pixel clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 en  input  1  pixel enable; counters advance only on cycles with en=1.
REQ-010 hcount, vcount  output  CW each  current pixel column and line.
REQ-011 hsync, vsync  output  1 each  sync pulses with HS_POL/VS_POL polarity applied.
REQ-012 hblnk, vblnk  output  1 each  high outside the active region of the respective axis.
REQ-013 end_of_line, end_of_frame, frame_start  output  1 each  single-cycle event strobes.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
REQ-015 hcount shall increment by 1 on each en=1 cycle and wrap from H_TOTAL-1 to 0.
REQ-016 vcount shall increment by 1 only on cycles where hcount wraps, and shall wrap from V_TOTAL-1 to 0 on the cycle both counters wrap.
REQ-017 With en=0, all counters and all outputs shall hold their values, except strobes, which shall be 0.
REQ-018 All outputs shall be registered and aligned with the hcount/vcount they describe; there shall be no combinational path from en to any output.
REQ-019 hblnk=1 iff hcount >= H_ACTIVE; vblnk=1 iff vcount >= V_ACTIVE.
REQ-020 The hsync asserted level shall be present iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 840..967); otherwise hsync shall be at its inactive level.
REQ-021 The vsync asserted level shall be present iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 601..604), for whole lines.
REQ-022 end_of_line=1 for exactly one en cycle, when hcount = H_TOTAL-1.
REQ-023 end_of_frame=1 when hcount = H_TOTAL-1 and vcount = V_TOTAL-1.
REQ-024 frame_start=1 when hcount = 0 and vcount = 0, including the first en cycle after reset.
REQ-025 Counter next-state arithmetic shall be CW bits wide and shall never produce values >= the respective total.

Reset
REQ-026 On rst=1 at a pclk edge: hcount=0, vcount=0, hblnk=0, vblnk=0, strobes=0, hsync/vsync at their inactive level; rst overrides en.
REQ-027 Reset asserted mid-frame shall restart timing at (0,0) with no partial sync pulse extended.

Structure
REQ-028 Default 800x600@60 timing constants and their derived totals shall reside in shared package vga_pkg; the module parameters shall default to those constants.
REQ-029 One sub-module, vga_axis_counter (parametrised modulo counter with count-enable input, count output and wrap strobe output), shall be instantiated twice: once for the horizontal axis and once for the vertical axis, chained by the horizontal wrap strobe.

Verification
REQ-030 Reset, then en=1 held for 1056 cycles -> hcount runs 0..1055 and wraps to 0; end_of_line is high only at 1055; vcount goes 0->1 on the wrap.
REQ-031 Full frame, defaults -> exactly 628 end_of_line strobes, exactly 1 end_of_frame strobe at (1055,627), and frame_start at (0,0).
REQ-032 Sync and blanking check -> hsync high for 128 cycles starting at hcount 840; vsync high during lines 601..604; hblnk rises at 800; vblnk rises at line 600.
REQ-033 Polarity and size override with HS_POL=0, VS_POL=0 and 640x480 timing (16/96/48, 10/2/33) -> H_TOTAL 800, V_TOTAL 525; hsync low during 656..751, high elsewhere.
REQ-034 en toggled randomly at 50% duty -> all outputs frozen on en=0 cycles, strobes 0 on en=0 cycles, and a frame completes after exactly 1056*628 en cycles.
REQ-035 rst asserted at hcount=900, vcount=602 (sync active) -> next cycle outputs (0,0) with hsync and vsync inactive; frame_start on the first en cycle after reset.
